phase_monitor: RTL and testbench

- Receiving-end checker for the five one-hot phase strobes: fetch, decode, exec, writeback and jump.
- Tracks the expected next phase and counts retired instructions.
- Flags sticky errors for non-one-hot strobes, out-of-order phases and missing strobes (timeout).
- Sits beside the phase generator, observing the strobe bus; feeds the debug/status register block.

---
 rtl/phase_monitor_if.sv | 25 ++
 rtl/phase_monitor.sv | 198 +++++++++++++++++++
 tb/tb_phase_monitor.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/phase_monitor_if.sv
// Phase strobe bus shared by the phase generator (master) and observers (slave).
// Signals: fetch_clk, decode_clk, exec_clk, wrbk_clk, jmp_clk -- one-hot phase strobes.
interface phase_monitor_if;
    logic fetch_clk;
    logic decode_clk;
    logic exec_clk;
    logic wrbk_clk;
    logic jmp_clk;

    modport master (
        output fetch_clk,
        output decode_clk,
        output exec_clk,
        output wrbk_clk,
        output jmp_clk
    );

    modport slave (
        input fetch_clk,
        input decode_clk,
        input exec_clk,
        input wrbk_clk,
        input jmp_clk
    );
endinterface

// File: rtl/phase_monitor.sv
// Receiving-end checker for the five one-hot phase strobes. Locks onto fetch,
// tracks the expected next phase, counts retired instructions and raises
// sticky errors for non-one-hot strobes, out-of-order phases and timeouts.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   strb            phase strobe bus (slave modport)
//   clear_i         synchronous clear of sticky errors and counter
//   phase_idx_o     last accepted phase 0..4, 7 when not locked
//   locked_o        high while in RUN
//   retire_o        one-cycle pulse per accepted jmp
//   instr_count_o   retired instruction count (wraps)
//   err_onehot_o, err_order_o, err_timeout_o, err_any_o  sticky errors
// Optional feature (macro PHASE_MON_CAPTURE_EN):
//   err_strobes_o   strobe snapshot at first error (0 for timeout)
//   err_expected_o  expected phase index at first error
module phase_monitor #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 4
) (
    input  logic               clk,
    input  logic               rst,
    phase_monitor_if.slave     strb,
    input  logic               clear_i,
    output logic [2:0]         phase_idx_o,
    output logic               locked_o,
    output logic               retire_o,
    output logic [CNT_W-1:0]   instr_count_o,
    output logic               err_onehot_o,
    output logic               err_order_o,
    output logic               err_timeout_o,
    output logic               err_any_o
`ifdef PHASE_MON_CAPTURE_EN
   ,output logic [4:0]         err_strobes_o,
    output logic [2:0]         err_expected_o
`endif
);

    localparam int unsigned STB_W    = 5;
    localparam int unsigned PH_W     = 3;
    localparam int unsigned GAP_W    = 8;
    localparam logic [PH_W-1:0] IDX_NONE  = 3'd7;
    localparam logic [PH_W-1:0] IDX_FETCH = 3'd0;
    localparam logic [PH_W-1:0] IDX_JMP   = 3'd4;

    typedef enum logic {SYNC, RUN} state_e;

    state_e            state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [PH_W-1:0]   expected_q, expected_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              locked_q, locked_d;
    logic              retire_q, retire_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              eonehot_q, eonehot_d;
    logic              eorder_q, eorder_d;
    logic              etimeout_q, etimeout_d;
    logic              eany_q, eany_d;

    logic [STB_W-1:0]  strobes;
    logic              none, multi, exp_hit;
    logic              set_onehot, set_order, set_timeout, new_err;

    assign strobes = {strb.jmp_clk, strb.wrbk_clk, strb.exec_clk, strb.decode_clk, strb.fetch_clk};
    assign none    = (strobes == '0);
    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign multi   = |(strobes & (strobes - STB_W'(1)));
    assign exp_hit = (strobes == (STB_W'(1) << expected_q));

    // Next-state, phase tracking and error detection.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        expected_d  = expected_q;
        gap_d       = gap_q;
        retire_d    = 1'b0;
        set_onehot  = 1'b0;
        set_order   = 1'b0;
        set_timeout = 1'b0;

        case (state_q)
            SYNC: begin
                if (multi) begin
                    set_onehot = 1'b1;
                end else if (strobes == STB_W'(1)) begin
                    state_d    = RUN;
                    phase_d    = IDX_FETCH;
                    expected_d = IDX_FETCH + PH_W'(1);
                    gap_d      = '0;
                end
            end
            RUN: begin
                if (none) begin
                    if (gap_q == GAP_W'(TIMEOUT - 1)) begin
                        set_timeout = 1'b1;
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end else if (multi) begin
                    set_onehot = 1'b1;
                end else if (exp_hit) begin
                    phase_d    = expected_q;
                    gap_d      = '0;
                    retire_d   = (expected_q == IDX_JMP);
                    expected_d = (expected_q == IDX_JMP) ? IDX_FETCH : expected_q + PH_W'(1);
                end else begin
                    set_order = 1'b1;
                end
            end
            default: state_d = SYNC;
        endcase

        new_err = set_onehot | set_order | set_timeout;
        // Any error in RUN drops lock; in SYNC this just restates reset values.
        if (new_err) begin
            state_d    = SYNC;
            phase_d    = IDX_NONE;
            expected_d = IDX_FETCH;
            gap_d      = '0;
        end

        // Clear wipes the sticky state, but an error found this cycle still sets.
        eonehot_d  = (eonehot_q  & ~clear_i) | set_onehot;
        eorder_d   = (eorder_q   & ~clear_i) | set_order;
        etimeout_d = (etimeout_q & ~clear_i) | set_timeout;
        eany_d     = eonehot_d | eorder_d | etimeout_d;
        count_d    = clear_i ? '0 : count_q + CNT_W'(retire_d);
        locked_d   = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= SYNC;
            phase_q    <= IDX_NONE;
            expected_q <= IDX_FETCH;
            gap_q      <= '0;
            locked_q   <= 1'b0;
            retire_q   <= 1'b0;
            count_q    <= '0;
            eonehot_q  <= 1'b0;
            eorder_q   <= 1'b0;
            etimeout_q <= 1'b0;
            eany_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            expected_q <= expected_d;
            gap_q      <= gap_d;
            locked_q   <= locked_d;
            retire_q   <= retire_d;
            count_q    <= count_d;
            eonehot_q  <= eonehot_d;
            eorder_q   <= eorder_d;
            etimeout_q <= etimeout_d;
            eany_q     <= eany_d;
        end
    end

    assign phase_idx_o   = phase_q;
    assign locked_o      = locked_q;
    assign retire_o      = retire_q;
    assign instr_count_o = count_q;
    assign err_onehot_o  = eonehot_q;
    assign err_order_o   = eorder_q;
    assign err_timeout_o = etimeout_q;
    assign err_any_o     = eany_q;

`ifdef PHASE_MON_CAPTURE_EN
    logic [STB_W-1:0] cap_stb_q, cap_stb_d;
    logic [PH_W-1:0]  cap_exp_q, cap_exp_d;

    // Capture only the first error; err_any_q low (or a clear) means nothing is held.
    always_comb begin
        cap_stb_d = cap_stb_q;
        cap_exp_d = cap_exp_q;
        if (new_err && (clear_i || !eany_q)) begin
            cap_stb_d = set_timeout ? '0 : strobes;
            cap_exp_d = expected_q;
        end else if (clear_i) begin
            cap_stb_d = '0;
            cap_exp_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_stb_q <= '0;
            cap_exp_q <= '0;
        end else begin
            cap_stb_q <= cap_stb_d;
            cap_exp_q <= cap_exp_d;
        end
    end

    assign err_strobes_o  = cap_stb_q;
    assign err_expected_o = cap_exp_q;
`endif

endmodule

// File: tb/tb_phase_monitor.sv
// Bench for phase_monitor: directed test-plan scenarios with literal
// expectations, then randomized strobe traffic against a behavioural model.
module tb_phase_monitor;

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned TIMEOUT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear = 1'b0;
    logic [2:0] phase_idx;
    logic locked, retire, err_onehot, err_order, err_timeout, err_any;
    logic [CNT_W-1:0] instr_count;
`ifdef PHASE_MON_CAPTURE_EN
    logic [4:0] err_strobes;
    logic [2:0] err_expected;
`endif

    phase_monitor_if strb_if ();

    phase_monitor #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst           (rst),
        .strb          (strb_if.slave),
        .clear_i       (clear),
        .phase_idx_o   (phase_idx),
        .locked_o      (locked),
        .retire_o      (retire),
        .instr_count_o (instr_count),
        .err_onehot_o  (err_onehot),
        .err_order_o   (err_order),
        .err_timeout_o (err_timeout),
        .err_any_o     (err_any)
`ifdef PHASE_MON_CAPTURE_EN
       ,.err_strobes_o (err_strobes),
        .err_expected_o(err_expected)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    // Behavioural model state: what the outputs must read after each edge.
    bit m_locked, m_retire, m_eo, m_ord, m_to;
    int m_phase, m_count, m_exp, m_gap, m_cs, m_ce;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_retire = 0; m_eo = 0; m_ord = 0; m_to = 0;
        m_phase = 7; m_count = 0; m_exp = 0; m_gap = 0; m_cs = 0; m_ce = 0;
    endtask

    task automatic model_step(input logic [4:0] s, input bit clr);
        int  ones;
        bit  err, any_before;
        int  snap, exp_at;
        ones = $countones(s);
        err = 0; snap = 0; exp_at = m_exp;
        any_before = m_eo | m_ord | m_to;
        m_retire = 0;
        if (clr) begin m_eo = 0; m_ord = 0; m_to = 0; end
        if (!m_locked) begin
            if (ones > 1) begin m_eo = 1; err = 1; snap = int'(s); end
            else if (s == 5'b00001) begin m_locked = 1; m_phase = 0; m_exp = 1; m_gap = 0; end
        end else if (ones == 0) begin
            if (m_gap == TIMEOUT - 1) begin m_to = 1; err = 1; snap = 0; end
            else m_gap++;
        end else if (ones > 1) begin
            m_eo = 1; err = 1; snap = int'(s);
        end else if (int'(s) == (1 << m_exp)) begin
            m_phase = m_exp; m_gap = 0;
            if (m_exp == 4) begin m_retire = 1; m_count = (m_count + 1) % (1 << CNT_W); end
            m_exp = (m_exp + 1) % 5;
        end else begin
            m_ord = 1; err = 1; snap = int'(s);
        end
        if (err) begin m_locked = 0; m_phase = 7; m_exp = 0; m_gap = 0; end
        if (clr) m_count = 0;
        if (err && (clr || !any_before)) begin m_cs = snap; m_ce = exp_at; end
        else if (clr) begin m_cs = 0; m_ce = 0; end
    endtask

    always @(negedge rst) model_reset();

    always @(posedge clk) begin
        if (!rst) model_reset();
        else model_step({strb_if.jmp_clk, strb_if.wrbk_clk, strb_if.exec_clk,
                         strb_if.decode_clk, strb_if.fetch_clk}, clear);
    end

    // Every-cycle comparison against the model on the inactive edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("phase_idx", int'(phase_idx), m_phase);
            chk("locked", int'(locked), int'(m_locked));
            chk("retire", int'(retire), int'(m_retire));
            chk("instr_count", int'(instr_count), m_count);
            chk("err_onehot", int'(err_onehot), int'(m_eo));
            chk("err_order", int'(err_order), int'(m_ord));
            chk("err_timeout", int'(err_timeout), int'(m_to));
            chk("err_any", int'(err_any), int'(m_eo | m_ord | m_to));
`ifdef PHASE_MON_CAPTURE_EN
            chk("err_strobes", int'(err_strobes), m_cs);
            chk("err_expected", int'(err_expected), m_ce);
`endif
        end
    end

    // Drive one cycle of inputs (called just after a rising edge), return just after the next one.
    task automatic tick(input logic [4:0] s, input bit c);
        strb_if.fetch_clk  = s[0];
        strb_if.decode_clk = s[1];
        strb_if.exec_clk   = s[2];
        strb_if.wrbk_clk   = s[3];
        strb_if.jmp_clk    = s[4];
        clear = c;
        @(posedge clk);
        #1;
    endtask

    task automatic clean_seq();
        for (int p = 0; p < 5; p++) tick(5'(1 << p), 1'b0);
    endtask

    initial begin
        logic [4:0] s;
        int r;
        strb_if.fetch_clk = 0; strb_if.decode_clk = 0; strb_if.exec_clk = 0;
        strb_if.wrbk_clk = 0; strb_if.jmp_clk = 0;
        #2 rst = 1'b0;
        cmp_en = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("reset_phase", int'(phase_idx), 7);
        chk("reset_locked", int'(locked), 0);
        chk("reset_count", int'(instr_count), 0);
        chk("reset_err_any", int'(err_any), 0);
        rst = 1'b1;

        // Three back-to-back clean instructions.
        for (int i = 0; i < 3; i++) begin
            for (int p = 0; p < 5; p++) begin
                tick(5'(1 << p), 1'b0);
                if (i == 0 && p == 0) begin
                    chk("lock_after_fetch", int'(locked), 1);
                    chk("phase_after_fetch", int'(phase_idx), 0);
                end
                if (p == 4) chk("retire_on_jmp", int'(retire), 1);
            end
        end
        chk("count_3", int'(instr_count), 3);
        chk("clean_err_any", int'(err_any), 0);

        // jmp where wrbk was expected.
        tick(5'b00001, 0); tick(5'b00010, 0); tick(5'b00100, 0); tick(5'b10000, 0);
        chk("order_err", int'(err_order), 1);
        chk("order_unlock", int'(locked), 0);
        chk("order_phase", int'(phase_idx), 7);
        chk("order_no_retire", int'(retire), 0);
        clean_seq();
        chk("relock_count", int'(instr_count), 4);
        chk("order_sticky", int'(err_order), 1);
        tick(5'b00000, 1);
        chk("clear_err_any", int'(err_any), 0);
        chk("clear_count", int'(instr_count), 0);

        // Timeout after decode.
        tick(5'b00001, 0); tick(5'b00010, 0);
        for (int k = 0; k < 3; k++) tick(5'b00000, 0);
        chk("no_timeout_yet", int'(err_timeout), 0);
        chk("still_locked", int'(locked), 1);
        tick(5'b00000, 0);
        chk("timeout_err", int'(err_timeout), 1);
        chk("timeout_unlock", int'(locked), 0);
`ifdef PHASE_MON_CAPTURE_EN
        chk("cap_timeout_stb", int'(err_strobes), 0);
        chk("cap_timeout_exp", int'(err_expected), 2);
`endif
        tick(5'b00000, 1);

        // Two strobes at once while locked.
        tick(5'b00001, 0); tick(5'b00101, 0);
        chk("onehot_err", int'(err_onehot), 1);
        chk("onehot_no_order", int'(err_order), 0);
        chk("onehot_unlock", int'(locked), 0);
`ifdef PHASE_MON_CAPTURE_EN
        chk("cap_onehot_stb", int'(err_strobes), 5);
`endif
        tick(5'b00000, 1);

        // Counter wrap, then clear coinciding with a retire.
        for (int i = 0; i < 16; i++) begin
            clean_seq();
            if (i == 14) chk("count_15", int'(instr_count), 15);
        end
        chk("count_wrap", int'(instr_count), 0);
        clean_seq();
        for (int p = 0; p < 4; p++) tick(5'(1 << p), 1'b0);
        tick(5'b10000, 1);
        chk("clear_retire_pulse", int'(retire), 1);
        chk("clear_retire_count", int'(instr_count), 0);

        // Asynchronous reset between edges, after exec.
        clean_seq();
        tick(5'b00001, 0); tick(5'b00010, 0); tick(5'b00100, 0);
        #2 rst = 1'b0;
        #1;
        chk("async_phase", int'(phase_idx), 7);
        chk("async_locked", int'(locked), 0);
        chk("async_count", int'(instr_count), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        tick(5'b01000, 0); tick(5'b10000, 0);
        chk("sync_ignore_lock", int'(locked), 0);
        chk("sync_ignore_err", int'(err_any), 0);
        clean_seq();
        chk("relock_retire", int'(retire), 1);
        chk("relock_count1", int'(instr_count), 1);

        // Randomized traffic, mostly legal with idles, bad strobes and clears mixed in.
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 70)      s = m_locked ? 5'(1 << m_exp) : 5'b00001;
            else if (r < 82) s = 5'b00000;
            else if (r < 92) s = 5'(1 << $urandom_range(0, 4));
            else             s = 5'($urandom);
            tick(s, ($urandom_range(0, 99) < 3));
        end
        tick(5'b00000, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
